// File: rtl/sync_nd_filt_c_ppp.sv
// Multi-bit level synchroniser: per-bit flop chain, optional stability filter,
// and single-cycle rise/fall pulses on the filtered level. Bits are fully independent.
module sync_nd_filt_c_ppp #(
  parameter int unsigned      WIDTH    = 4,
  parameter int unsigned      STAGES   = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int unsigned      FILT_CNT = 0
) (
  input  logic             clk,
  input  logic             clr_,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg
);

  if (STAGES < 2) begin : g_stages_chk
    $error("sync_nd_filt_c_ppp: STAGES must be >= 2");
  end

  // Chain flops feed nothing but the next stage; tools must keep them as sync cells.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] q_lvl;
  logic [WIDTH-1:0] q_prev_q;

  assign synced = sync_q[STAGES-1];

  if (FILT_CNT == 0) begin : g_bypass
    assign q_lvl = synced;
  end else begin : g_filt
    localparam int unsigned      CNT_W  = (FILT_CNT < 2) ? 1 : $clog2(FILT_CNT + 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(FILT_CNT - 1);

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            lvl_q, lvl_d;

    // A bit's level only moves after the synced value disagrees for FILT_CNT cycles in a row.
    always_comb begin
      lvl_d = lvl_q;
      cnt_d = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
        if (synced[i] == lvl_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          lvl_d[i] = synced[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
        lvl_q <= RST_VAL;
        cnt_q <= '0;
      end else begin
        lvl_q <= lvl_d;
        cnt_q <= cnt_d;
      end
    end

    assign q_lvl = lvl_q;
  end

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      q_prev_q <= RST_VAL;
    end else begin
      q_prev_q <= q_lvl;
    end
  end

  assign q    = q_lvl;
  assign rise = q_lvl & ~q_prev_q;
  assign fall = ~q_lvl & q_prev_q;
  assign chg  = |(rise | fall);

endmodule

// File: tb/tb_sync_nd_filt_c_ppp.sv
// Bench for sync_nd_filt_c_ppp: four parameterisations driven together, directed
// scenarios plus randomized stimulus against a delay-line / run-length reference.
module tb_sync_nd_filt_c_ppp;

  localparam int unsigned PW [4] = '{4, 4, 1, 8};
  localparam int unsigned PS [4] = '{3, 3, 2, 4};
  localparam int unsigned PK [4] = '{0, 4, 1, 7};
  localparam logic [7:0]  PR [4] = '{8'h00, 8'h00, 8'h01, 8'hA5};

  logic       clk;
  logic       clr  [4];
  logic [7:0] din  [4];

  logic [3:0] q0, r0, f0;
  logic [3:0] q1, r1, f1;
  logic       q2, r2, f2;
  logic [7:0] q3, r3, f3;
  logic       c0, c1, c2, c3;

  logic [7:0] dq [4];
  logic [7:0] dr [4];
  logic [7:0] df [4];
  logic       dc [4];

  assign dq[0] = {4'h0, q0};
  assign dr[0] = {4'h0, r0};
  assign df[0] = {4'h0, f0};
  assign dc[0] = c0;
  assign dq[1] = {4'h0, q1};
  assign dr[1] = {4'h0, r1};
  assign df[1] = {4'h0, f1};
  assign dc[1] = c1;
  assign dq[2] = {7'h0, q2};
  assign dr[2] = {7'h0, r2};
  assign df[2] = {7'h0, f2};
  assign dc[2] = c2;
  assign dq[3] = q3;
  assign dr[3] = r3;
  assign df[3] = f3;
  assign dc[3] = c3;

  sync_nd_filt_c_ppp #(.WIDTH(4), .STAGES(3), .RST_VAL(4'h0), .FILT_CNT(0)) u0 (
    .clk(clk), .clr_(clr[0]), .d(din[0][3:0]), .q(q0), .rise(r0), .fall(f0), .chg(c0)
  );
  sync_nd_filt_c_ppp #(.WIDTH(4), .STAGES(3), .RST_VAL(4'h0), .FILT_CNT(4)) u1 (
    .clk(clk), .clr_(clr[1]), .d(din[1][3:0]), .q(q1), .rise(r1), .fall(f1), .chg(c1)
  );
  sync_nd_filt_c_ppp #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b1), .FILT_CNT(1)) u2 (
    .clk(clk), .clr_(clr[2]), .d(din[2][0]), .q(q2), .rise(r2), .fall(f2), .chg(c2)
  );
  sync_nd_filt_c_ppp #(.WIDTH(8), .STAGES(4), .RST_VAL(8'hA5), .FILT_CNT(7)) u3 (
    .clk(clk), .clr_(clr[3]), .d(din[3]), .q(q3), .rise(r3), .fall(f3), .chg(c3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: d seen through an STAGES-long delay line, then a per-bit run-length filter.
  logic [7:0] mh    [4][4];
  logic [7:0] mq    [4];
  logic [7:0] mprev [4];
  int         run   [4][8];

  function automatic logic [7:0] mask(input int i);
    return 8'((16'd1 << PW[i]) - 16'd1);
  endfunction

  task automatic model_reset(input int i);
    for (int s = 0; s < 4; s++) mh[i][s] = PR[i];
    mq[i]    = PR[i];
    mprev[i] = PR[i];
    for (int b = 0; b < 8; b++) run[i][b] = 0;
  endtask

  task automatic model_step(input int i);
    logic [7:0] seen;
    logic [7:0] old_q;
    if (!clr[i]) begin
      model_reset(i);
      return;
    end
    seen  = mh[i][PS[i]-1];
    old_q = mq[i];
    for (int s = 3; s > 0; s--) mh[i][s] = mh[i][s-1];
    mh[i][0] = din[i] & mask(i);
    if (PK[i] == 0) begin
      mq[i] = mh[i][PS[i]-1];
    end else begin
      for (int b = 0; b < int'(PW[i]); b++) begin
        if (seen[b] != mq[i][b]) begin
          run[i][b]++;
          if (run[i][b] == int'(PK[i])) begin
            mq[i][b]  = seen[b];
            run[i][b] = 0;
          end
        end else begin
          run[i][b] = 0;
        end
      end
    end
    mprev[i] = old_q;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      clr[i] = 1'b0;
      din[i] = 8'hFF;
      model_reset(i);
    end
    for (int t = 0; t < 10; t++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dq[i] !== PR[i] || dr[i] !== 8'h00 || df[i] !== 8'h00 || dc[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset inst%0d t%0d: q=%h rise=%h fall=%h chg=%b, want q=%h and no pulses",
                   i, t, dq[i], dr[i], df[i], dc[i], PR[i]);
        end
      end
    end
  endtask

  task automatic test_latency();
    din[0] = 8'h00;
    for (int i = 0; i < 4; i++) clr[i] = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    din[0] = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (dq[0][0] !== (k >= 3) || dr[0][0] !== (k == 3) || dc[0] !== (k == 3)) begin
        errors++;
        $display("FAIL latency edge%0d: q0=%b rise0=%b chg=%b, want q0=%b rise0=%b chg=%b",
                 k, dq[0][0], dr[0][0], dc[0], k >= 3, k == 3, k == 3);
      end
    end
  endtask

  task automatic test_filter();
    din[1] = 8'h00;
    for (int t = 0; t < 8; t++) tick();
    din[1] = 8'h02;
    tick();
    tick();
    din[1] = 8'h00;
    for (int t = 0; t < 12; t++) begin
      tick();
      checks++;
      if (dq[1] !== 8'h00 || dr[1] !== 8'h00 || dc[1] !== 1'b0) begin
        errors++;
        $display("FAIL filter_glitch t%0d: q=%h rise=%h chg=%b, want q=00 and no pulse",
                 t, dq[1], dr[1], dc[1]);
      end
    end
    din[1] = 8'h02;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (dq[1][1] !== (k >= 7) || dr[1][1] !== (k == 7)) begin
        errors++;
        $display("FAIL filter_edge edge%0d: q1=%b rise1=%b, want q1=%b rise1=%b",
                 k, dq[1][1], dr[1][1], k >= 7, k == 7);
      end
    end
  endtask

  task automatic test_edges();
    din[0] = 8'h04;
    for (int t = 0; t < 6; t++) tick();
    checks++;
    if (dq[0] !== 8'h04) begin
      errors++;
      $display("FAIL edges_setup: q=%h, want 04", dq[0]);
    end
    din[0] = 8'h01;
    tick();
    tick();
    checks++;
    if (dr[0] !== 8'h00 || df[0] !== 8'h00 || dc[0] !== 1'b0) begin
      errors++;
      $display("FAIL edges_early: rise=%h fall=%h chg=%b, want no pulse", dr[0], df[0], dc[0]);
    end
    tick();
    checks++;
    if (dq[0] !== 8'h01 || dr[0] !== 8'h01 || df[0] !== 8'h04 || dc[0] !== 1'b1) begin
      errors++;
      $display("FAIL edges_simul: q=%h rise=%h fall=%h chg=%b, want q=01 rise=01 fall=04 chg=1",
               dq[0], dr[0], df[0], dc[0]);
    end
    tick();
    checks++;
    if (dr[0] !== 8'h00 || df[0] !== 8'h00 || dc[0] !== 1'b0) begin
      errors++;
      $display("FAIL edges_single: rise=%h fall=%h chg=%b, want no pulse", dr[0], df[0], dc[0]);
    end
  endtask

  task automatic test_reset_mid();
    din[1] = 8'h0F;
    for (int t = 0; t < 10; t++) tick();
    checks++;
    if (dq[1] !== 8'h0F) begin
      errors++;
      $display("FAIL rstmid_setup: q=%h, want 0f", dq[1]);
    end
    din[1] = 8'h00;
    for (int t = 0; t < 5; t++) tick();
    checks++;
    if (dq[1] !== 8'h0F) begin
      errors++;
      $display("FAIL rstmid_hold: q=%h, want 0f while count is partial", dq[1]);
    end
    #2;
    clr[1] = 1'b0;
    model_reset(1);
    #1;
    checks++;
    if (dq[1] !== 8'h00 || dc[1] !== 1'b0 || df[1] !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async: q=%h fall=%h chg=%b, want q=00 and no pulse",
               dq[1], df[1], dc[1]);
    end
    tick();
    clr[1] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if (dq[1] !== 8'h00 || dr[1] !== 8'h00 || df[1] !== 8'h00 || dc[1] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet t%0d: q=%h rise=%h fall=%h chg=%b, want q=00 and no pulses",
                 t, dq[1], dr[1], df[1], dc[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!clr[i]) begin
          if ($urandom_range(1, 0) == 1) clr[i] = 1'b1;
        end else if ($urandom_range(99, 0) == 0) begin
          clr[i] = 1'b0;
          model_reset(i);
        end
        if ($urandom_range(7, 0) == 0) begin
          din[i] = 8'($urandom) & mask(i);
        end else if ($urandom_range(3, 0) == 0) begin
          din[i] = din[i] ^ (8'(1 << $urandom_range(PW[i] - 1, 0)) & mask(i));
        end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        logic [7:0] er, ef;
        er = mq[i] & ~mprev[i];
        ef = ~mq[i] & mprev[i] & mask(i);
        checks++;
        if (dq[i] !== mq[i] || dr[i] !== er || df[i] !== ef || dc[i] !== |(er | ef)) begin
          errors++;
          $display("FAIL random inst%0d t%0d: q=%h rise=%h fall=%h chg=%b, want q=%h rise=%h fall=%h chg=%b",
                   i, t, dq[i], dr[i], df[i], dc[i], mq[i], er, ef, |(er | ef));
        end
        checks++;
        if ((dr[i] & df[i]) !== 8'h00) begin
          errors++;
          $display("FAIL rise_and_fall inst%0d t%0d: rise&fall=%h, want 00", i, t, dr[i] & df[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      clr[i] = 1'b0;
      din[i] = 8'h00;
      model_reset(i);
    end
    test_reset();
    test_latency();
    test_filter();
    test_edges();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
